// File: rtl/mining_pkg.sv
// -----------------------------------------------------------------------------
// mining_pkg
// Shared definitions for the mining datapath FSMs: digest/word/nonce widths,
// the state encoding and the difficulty clamp helper.
// No ports (package).
// -----------------------------------------------------------------------------
package mining_pkg;

   localparam int DIGEST_W         = 256;
   localparam int WORD_W           = 32;
   localparam int NONCE_W          = 16;
   localparam int WORDS_PER_DIGEST = DIGEST_W / WORD_W;
   localparam int LZ_W             = 9;   // 0..256 leading zeros
   localparam int IDX_W            = 3;   // word index 0..7
   localparam int DIFF_W           = 9;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_NEXT  = 3'd2,
      ST_SEND  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Targets above the digest width cannot be exceeded by any digest, so they
   // collapse to "all bits zero".
   function automatic logic [LZ_W-1:0] clamp_difficulty(input logic [DIFF_W-1:0] d);
      if (d > DIFF_W'(DIGEST_W)) begin
         return LZ_W'(DIGEST_W);
      end
      return d;
   endfunction

endpackage

// File: rtl/mining_hash_reader_lzc256.sv
// -----------------------------------------------------------------------------
// lzc256
// Combinational leading-zero counter over a 256-bit digest.
// Ports:
//   data_i  [255:0] in  : value to scan, bit 255 is the MSB
//   count_o [8:0]   out : number of leading zero bits, 256 for an all-zero input
// -----------------------------------------------------------------------------
module lzc256
   import mining_pkg::*;
(
   input  logic [DIGEST_W-1:0] data_i,
   output logic [LZ_W-1:0]     count_o
);

   // Scan from LSB upward; the last set bit seen is the most significant one,
   // so it wins and defines the count.
   always_comb begin
      count_o = LZ_W'(DIGEST_W);
      for (int i = 0; i < DIGEST_W; i++) begin
         if (data_i[i]) begin
            count_o = LZ_W'(DIGEST_W - 1 - i);
         end
      end
   end

endmodule

// File: rtl/mining_hash_reader.sv
// -----------------------------------------------------------------------------
// mining_hash_reader
// Consumer end of the mining datapath. Captures a digest on `fine`, compares its
// leading-zero count against the difficulty target, requests the next nonce on
// a miss, and streams the digest as eight 32-bit words on a hit, then holds
// until `restart`.
// Ports:
//   clock        in   : rising-edge clock
//   reset        in   : asynchronous active-high reset, clears all state
//   fine         in   : one-cycle pulse, HASH valid
//   HASH [255:0] in   : digest, bit 255 = MSB
//   difficulty[8:0] in: required leading zero bits (values >256 clamp to 256)
//   restart      in   : clear nonce/found/sticky flags, return to idle
//   out_ready    in   : downstream accepts the current word
//   out_data[31:0] out: current digest word, MSW first
//   out_valid    out  : out_data valid
//   out_last     out  : high with the eighth word
//   found        out  : held from hit until restart/reset
//   nonce [15:0] out  : current nonce (winning nonce once found)
//   nonce_inc    out  : one-cycle pulse requesting the next nonce
//   wrapped      out  : sticky, nonce rolled over 0xFFFF -> 0
//   overrun      out  : sticky, fine arrived while busy
// -----------------------------------------------------------------------------
module mining_hash_reader
   import mining_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                fine,
   input  logic [DIGEST_W-1:0] HASH,
   input  logic [DIFF_W-1:0]   difficulty,
   input  logic                restart,
   input  logic                out_ready,
   output logic [WORD_W-1:0]   out_data,
   output logic                out_valid,
   output logic                out_last,
   output logic                found,
   output logic [NONCE_W-1:0]  nonce,
   output logic                nonce_inc,
   output logic                wrapped,
   output logic                overrun
);

   state_e               state_q,   state_d;
   logic [DIGEST_W-1:0]  digest_q,  digest_d;
   logic [IDX_W-1:0]     idx_q,     idx_d;
   logic [NONCE_W-1:0]   nonce_q,   nonce_d;
   logic                 found_q,   found_d;
   logic                 wrapped_q, wrapped_d;
   logic                 overrun_q, overrun_d;

   logic [LZ_W-1:0]      lz;
   logic                 hit;

   function automatic logic [WORD_W-1:0] word_sel(input logic [DIGEST_W-1:0] d,
                                                  input logic [IDX_W-1:0]    i);
      word_sel = '0;
      for (int w = 0; w < WORDS_PER_DIGEST; w++) begin
         if (i == IDX_W'(w)) begin
            word_sel = d[DIGEST_W-1-WORD_W*w -: WORD_W];
         end
      end
   endfunction

   lzc256 u_lzc (
      .data_i  (digest_q),
      .count_o (lz)
   );

   // difficulty is only consulted while in CHECK
   assign hit = (lz >= clamp_difficulty(difficulty));

   always_comb begin
      state_d   = state_q;
      digest_d  = digest_q;
      idx_d     = idx_q;
      nonce_d   = nonce_q;
      found_d   = found_q;
      wrapped_d = wrapped_q;
      overrun_d = overrun_q;

      if (restart) begin
         // restart beats everything, including a simultaneous fine
         state_d   = ST_IDLE;
         idx_d     = '0;
         nonce_d   = '0;
         found_d   = 1'b0;
         wrapped_d = 1'b0;
         overrun_d = 1'b0;
      end else begin
         if (fine && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
         end
         unique case (state_q)
            ST_IDLE: begin
               if (fine) begin
                  digest_d = HASH;
                  state_d  = ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (hit) begin
                  found_d = 1'b1;
                  idx_d   = '0;
                  state_d = ST_SEND;
               end else begin
                  state_d = ST_NEXT;
               end
            end
            ST_NEXT: begin
               nonce_d = nonce_q + NONCE_W'(1);
               if (nonce_q == '1) begin
                  wrapped_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
            ST_SEND: begin
               if (out_ready) begin
                  if (idx_q == IDX_W'(WORDS_PER_DIGEST - 1)) begin
                     state_d = ST_DONE;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         digest_q  <= '0;
         idx_q     <= '0;
         nonce_q   <= '0;
         found_q   <= 1'b0;
         wrapped_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         digest_q  <= digest_d;
         idx_q     <= idx_d;
         nonce_q   <= nonce_d;
         found_q   <= found_d;
         wrapped_q <= wrapped_d;
         overrun_q <= overrun_d;
      end
   end

   // Outputs decode straight from registered state, so a reset drops the
   // stream immediately without a final out_last.
   assign out_valid = (state_q == ST_SEND);
   assign out_last  = out_valid && (idx_q == IDX_W'(WORDS_PER_DIGEST - 1));
   assign out_data  = out_valid ? word_sel(digest_q, idx_q) : '0;
   assign nonce_inc = (state_q == ST_NEXT);
   assign found     = found_q;
   assign nonce     = nonce_q;
   assign wrapped   = wrapped_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_mining_hash_reader.sv
module tb_mining_hash_reader;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         fine = 1'b0;
   logic [255:0] HASH = '0;
   logic [8:0]   difficulty = '0;
   logic         restart = 1'b0;
   logic         out_ready = 1'b0;
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_last;
   logic         found;
   logic [15:0]  nonce;
   logic         nonce_inc;
   logic         wrapped;
   logic         overrun;

   logic [255:0] lz_in = '0;
   logic [8:0]   lz_out;

   int total = 0;
   int bad   = 0;

   // expected behaviour
   logic [31:0] exp_q[$];
   int          inc_pending = 0;
   int          xfer_cnt = 0;

   mining_hash_reader dut (
      .clock      (clock),
      .reset      (reset),
      .fine       (fine),
      .HASH       (HASH),
      .difficulty (difficulty),
      .restart    (restart),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .found      (found),
      .nonce      (nonce),
      .nonce_inc  (nonce_inc),
      .wrapped    (wrapped),
      .overrun    (overrun)
   );

   lzc256 u_lzc (
      .data_i  (lz_in),
      .count_o (lz_out)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   // model: count zeros from the MSB down until the first one
   function automatic int lz_model(input logic [255:0] h);
      int n = 0;
      while (n < 256 && h[255-n] == 1'b0) n++;
      return n;
   endfunction

   function automatic bit is_hit(input logic [255:0] h, input int diff);
      int target = (diff > 256) ? 256 : diff;
      return lz_model(h) >= target;
   endfunction

   // compare process: stream content/order, out_last placement, nonce requests
   always @(negedge clock) begin
      if (!reset) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", out_valid, 1'b0);
            end else begin
               chk("out_data", out_data, exp_q[0]);
               chk("out_last", out_last, exp_q.size() == 1);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  xfer_cnt++;
               end
            end
         end else begin
            chk("last_without_valid", out_last, 1'b0);
         end
         if (nonce_inc) begin
            if (inc_pending == 0) chk("unexpected_nonce_inc", nonce_inc, 1'b0);
            else inc_pending--;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic fire(input logic [255:0] h, input int diff);
      HASH       = h;
      difficulty = 9'(diff);
      fine       = 1'b1;
      tick();
      fine       = 1'b0;
   endtask

   task automatic expect_hash(input logic [255:0] h, input int diff);
      if (is_hit(h, diff)) begin
         for (int k = 0; k < 8; k++) exp_q.push_back(h[255-32*k -: 32]);
      end else begin
         inc_pending++;
      end
   endtask

   task automatic drain(input int budget, input bit random_ready);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         if (random_ready) out_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      chk("drain_timeout", exp_q.size(), 0);
      out_ready = 1'b1;
   endtask

   task automatic run_hash(input logic [255:0] h, input int diff, input bit random_ready);
      expect_hash(h, diff);
      fire(h, diff);
      if (is_hit(h, diff)) drain(400, random_ready);
      else begin
         tick();
         tick();
      end
   endtask

   task automatic do_restart();
      restart = 1'b1;
      tick();
      restart = 1'b0;
   endtask

   logic [255:0] H1, H2, HZ, HONE;

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      H1   = {32'h000000FF, {7{32'hAAAAAAAA}}};
      HZ   = '0;
      HONE = 256'd1;

      // model pins
      chk("model_lz_H1", lz_model(H1), 24);
      chk("model_lz_zero", lz_model(HZ), 256);
      chk("model_hit_H1_24", is_hit(H1, 24), 1);
      chk("model_hit_H1_25", is_hit(H1, 25), 0);

      // standalone leading-zero counter
      lz_in = HZ;          #1; chk("lzc_zero", lz_out, 256);
      lz_in = HONE;        #1; chk("lzc_one", lz_out, 255);
      lz_in = {1'b1, 255'd0}; #1; chk("lzc_msb", lz_out, 0);
      lz_in = HONE << 100; #1; chk("lzc_bit100", lz_out, 155);
      lz_in = H1;          #1; chk("lzc_H1", lz_out, lz_model(H1));

      // reset state
      tick(); tick();
      chk("rst_valid", out_valid, 0); chk("rst_last", out_last, 0);
      chk("rst_data", out_data, 0);   chk("rst_found", found, 0);
      chk("rst_nonce", nonce, 0);     chk("rst_inc", nonce_inc, 0);
      chk("rst_wrapped", wrapped, 0); chk("rst_overrun", overrun, 0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_quiet", {out_valid, found, nonce_inc, wrapped, overrun, nonce}, '0);
      end

      // hit at difficulty 24, ready tied high, latency pinned
      out_ready = 1'b1;
      xfer_cnt  = 0;
      expect_hash(H1, 24);
      fire(H1, 24);
      chk("check_no_valid", out_valid, 0);
      tick();
      chk("e1_valid", out_valid, 1);
      chk("e1_word0", out_data, 32'h000000FF);
      chk("e1_found", found, 1);
      drain(20, 0);
      chk("hit_xfers", xfer_cnt, 8);
      chk("done_valid", out_valid, 0);
      chk("done_found", found, 1);
      chk("done_nonce", nonce, 0);

      // miss at difficulty 25
      do_restart();
      chk("restart_found", found, 0);
      inc_pending = 1;
      fire(H1, 25);
      chk("miss_e0_inc", nonce_inc, 0);
      tick();
      chk("miss_e1_inc", nonce_inc, 1);
      chk("miss_e1_nonce", nonce, 0);
      tick();
      chk("miss_e2_inc", nonce_inc, 0);
      chk("miss_e2_nonce", nonce, 1);
      chk("miss_valid", out_valid, 0);
      chk("miss_pending", inc_pending, 0);

      // difficulty 0, random digest, random backpressure
      H2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      xfer_cnt = 0;
      run_hash(H2, 0, 1);
      chk("rand_xfers", xfer_cnt, 8);
      chk("rand_found", found, 1);
      chk("rand_nonce_frozen", nonce, 1);

      // fine during SEND is ignored but flagged
      do_restart();
      xfer_cnt = 0;
      expect_hash(H1, 24);
      fire(H1, 24);
      tick();
      HASH = ~H1;
      fine = 1'b1;
      tick();
      fine = 1'b0;
      drain(20, 0);
      chk("ovr_xfers", xfer_cnt, 8);
      chk("ovr_flag", overrun, 1);

      // restart in DONE
      do_restart();
      chk("rs_found", found, 0);
      chk("rs_nonce", nonce, 0);
      chk("rs_overrun", overrun, 0);
      chk("rs_valid", out_valid, 0);

      // restart together with fine: fine is dropped
      restart = 1'b1;
      HASH = H1; difficulty = 9'd0; fine = 1'b1;
      tick();
      restart = 1'b0; fine = 1'b0;
      tick(); tick(); tick();
      chk("rsf_valid", out_valid, 0);
      chk("rsf_found", found, 0);
      chk("rsf_overrun", overrun, 0);

      // clamp boundaries
      run_hash(HZ, 511, 0);
      chk("clamp_zero_hit", found, 1);
      do_restart();
      run_hash(HONE, 300, 0);
      chk("clamp_255_miss", found, 0);
      chk("clamp_nonce", nonce, 1);

      // nonce rollover
      force dut.nonce_q = 16'hFFFF;
      tick();
      release dut.nonce_q;
      tick();
      chk("preload_nonce", nonce, 16'hFFFF);
      run_hash(H1, 25, 0);
      chk("wrap_nonce", nonce, 0);
      chk("wrap_flag", wrapped, 1);

      // reset in the middle of a stream
      expect_hash(H1, 24);
      fire(H1, 24);
      tick();
      tick();
      #3;
      reset = 1'b1;
      #1;
      chk("abort_valid", out_valid, 0);
      chk("abort_last", out_last, 0);
      chk("abort_found", found, 0);
      chk("abort_wrapped", wrapped, 0);
      exp_q.delete();
      @(posedge clock);
      #1;
      reset = 1'b0;
      tick();

      // still functional after abort
      xfer_cnt = 0;
      run_hash({8'h00, 248'h5A5A}, 8, 1);
      chk("post_xfers", xfer_cnt, 8);
      chk("post_found", found, 1);
      chk("inc_balance", inc_pending, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mining_hash_reader.md
# mining_hash_reader

Consumer end of the mining datapath: receives the 256-bit digest produced by the chunk/hash stage when `fine` pulses, checks it against a leading-zero difficulty target and decides the outcome. A miss requests the next nonce. A hit streams the digest out as eight 32-bit words over a valid/ready handshake and halts the search until `restart`. It owns the nonce counter that feeds the preprocessing stage's `indirizzo_nonce`.

## Interface
- `DIGEST_W`, 256: digest width; fixed.
- `WORD_W`, 32: output word width; `DIGEST_W/WORD_W` = 8 words.
- `NONCE_W`, 16: nonce counter width; matches `indirizzo_nonce`.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `fine`  in  1: one-cycle pulse, `HASH` valid this cycle.
- `HASH`  in  256: digest, bit 255 = MSB.
- `difficulty`  in  9: required leading zero bits, 0..511; values >256 clamp to 256.
- `restart`  in  1: pulse; clear nonce/found, return to IDLE.
- `out_ready`  in  1: downstream accepts word.
- `out_data`  out  32: current digest word.
- `out_valid`  out  1: `out_data` valid.
- `out_last`  out  1: high with word 7.
- `found`  out  1: held high from hit until `restart`/`reset`.
- `nonce`  out  16: current nonce.
- `nonce_inc`  out  1: one-cycle pulse, next nonce requested.
- `wrapped`  out  1: sticky, nonce rolled 0xFFFF→0.
- `overrun`  out  1: sticky, `fine` arrived outside IDLE.

## Operation
- Reset values: all outputs 0; state IDLE; digest register 0; word index 0.
- States (3-bit): IDLE, CHECK, NEXT, SEND, DONE.
- IDLE: `fine`=1 → capture `HASH`, go CHECK.
- CHECK: lz = leading zeros of captured digest (0..256). If lz ≥ clamped `difficulty` → `found`=1, word index 0, go SEND. Otherwise go NEXT.
- NEXT: `nonce_inc`=1 for exactly this cycle; at the end of the cycle `nonce`←`nonce`+1 modulo 2^16; on 0xFFFF→0 set `wrapped`; go IDLE.
- SEND: `out_valid`=1, `out_data` = digest[255-32i -: 32] for index i. Advance i on `out_valid & out_ready`. `out_last`=1 when i=7. A handshake on i=7 goes to DONE. `out_data` stays stable while `out_ready`=0.
- DONE: `out_valid`=0, `found` held, `nonce` frozen (it is the winning nonce).
- `difficulty`=0: every digest is a hit.
- `fine` in any state other than IDLE: ignored, `overrun`←1. Digest is not recaptured.
- `restart` has priority in every state: next state IDLE, `nonce`←0, `found`←0, `out_valid`←0. It also clears `wrapped` and `overrun`. If `restart` and `fine` occur together, `fine` is dropped.
- `reset` mid-SEND aborts the stream immediately, with no `out_last`.

## Timing
- `fine` sampled at edge E0 → CHECK after E0.
- Edge E1 → SEND (`out_valid`=1) or NEXT (`nonce_inc`=1) after E1.
- Miss: `nonce` updates at E2; IDLE after E2. `fine`-to-ready-for-next-`fine` = 3 cycles.
- Hit with `out_ready` tied high: words 0..7 accepted at E2..E9; DONE after E9.
- `difficulty` is sampled in CHECK only.

## Structure
- Shared package `mining_pkg`: state encoding constants, `DIGEST_W`, `WORD_W`, `NONCE_W`, `WORDS_PER_DIGEST`=8. The other mining FSMs reuse these.
- Sub-module `lzc256`: combinational 256-bit leading-zero counter, 9-bit result (256 for all-zero input). Verify it standalone.
- The rest is one module: FSM, digest register, word index, nonce counter, sticky flags.

## Test plan
- Reset → all outputs 0. Release reset, hold idle 10 cycles → no change.
- `HASH`=0x000000FF followed by 0xAA…AA, `difficulty`=24 → hit. Words 0x000000FF, then 0xAAAAAAAA ×7. `out_last` only on the 8th word, `nonce`=0, DONE after 8 handshakes.
- Same `HASH`, `difficulty`=25 → miss. `nonce_inc` pulses once at E1, `nonce` 0→1, no `out_valid`.
- Hit with `out_ready` toggled pseudo-randomly → `out_data` stable whenever `out_valid & !out_ready`. Exactly 8 transfers, in order.
- Preload 65535 misses (or force `nonce`=0xFFFF), then one miss → `nonce`=0, `wrapped`=1.
- `fine` pulsed during SEND → `overrun`=1, stream unaffected. `restart` in DONE → `found`=0, `nonce`=0, `overrun`=0, IDLE. `difficulty`=0 with random `HASH` → hit.
